a2d_rr_seq: RTL

Round-robin conversion scheduler that shares the single SPI master and external 8-channel ADC between the four analog quantities the balance platform needs: left load cell, right load cell, steering pot and battery. Each nxt request performs one two-transaction ADC conversion for the current channel, latches the 12-bit result and advances to the next channel. The latched load-cell outputs feed the steering-enable logic directly. The ld_vld output tells downstream logic when a fresh left/right pair is available.

---
 rtl/a2d_rr_seq_if.sv | 14 +
 rtl/a2d_rr_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/a2d_rr_seq_if.sv
// SPI transaction link between the conversion scheduler and the SPI master.
//   wrt     : single-cycle transaction start
//   cmd     : 16-bit command word, stable while the transaction runs
//   done    : single-cycle end-of-transaction pulse
//   rd_data : read data, valid while done is high
interface a2d_rr_seq_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/a2d_rr_seq.sv
// Round-robin A2D conversion scheduler: each nxt runs one two-transaction
// ADC conversion on the current channel, latches the 12-bit result and
// advances to the next channel (left, right, steer, battery).
//   clk, rst_n : clock, asynchronous active-low reset
//   nxt        : request the next conversion (queued once if busy)
//   spi        : SPI master link (master modport)
//   lft_ld, rght_ld, steer_pot, batt : latest 12-bit results
//   ld_vld     : pulse when rght_ld updates (fresh left/right pair)
//   busy       : conversion in progress
//   a2d_err    : pulse when the SPI master fails to answer in time
module a2d_rr_seq #(
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_STEER = 3'd5,
    parameter logic [2:0]  CH_BATT  = 3'd6,
    parameter int unsigned TMO_W    = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               nxt,
    a2d_rr_seq_if.master       spi,
    output logic [11:0]        lft_ld,
    output logic [11:0]        rght_ld,
    output logic [11:0]        steer_pot,
    output logic [11:0]        batt,
    output logic               ld_vld,
    output logic               busy,
    output logic               a2d_err
);

    // One short of all-ones: the error flop then fires on the edge where
    // the counter itself reaches all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TX1  = 3'd1,
        GAP  = 3'd2,
        TX2  = 3'd3,
        CAPT = 3'd4
    } state_t;

    state_t           state;
    logic [1:0]       rr;
    logic             pend;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       chan;

    // Only the low 12 bits of the read word carry the conversion result.
    logic unused_rd_hi;
    assign unused_rd_hi = ^spi.rd_data[15:12];

    // Channel address selected by the round-robin pointer.
    always_comb begin
        chan = CH_LFT;
        case (rr)
            2'd1:    chan = CH_RGHT;
            2'd2:    chan = CH_STEER;
            2'd3:    chan = CH_BATT;
            default: chan = CH_LFT;
        endcase
    end

    // Conversion sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 2'd0;
            pend      <= 1'b0;
            tmo_cnt   <= '0;
            spi.wrt   <= 1'b0;
            spi.cmd   <= 16'h0000;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
            ld_vld    <= 1'b0;
            busy      <= 1'b0;
            a2d_err   <= 1'b0;
        end else begin
            spi.wrt <= 1'b0;
            ld_vld  <= 1'b0;
            a2d_err <= 1'b0;

            // Single-entry request queue; extra requests are dropped.
            if (nxt && (state != IDLE)) begin
                pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (nxt || pend) begin
                        state   <= TX1;
                        spi.wrt <= 1'b1;
                        spi.cmd <= {2'b00, chan, 11'h000};
                        pend    <= 1'b0;
                        tmo_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                TX1: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (spi.done) begin
                        state <= GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= IDLE;
                        a2d_err <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                GAP: begin
                    state   <= TX2;
                    spi.wrt <= 1'b1;
                    tmo_cnt <= '0;
                end
                TX2: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (spi.done) begin
                        state <= CAPT;
                        case (rr)
                            2'd0: lft_ld    <= spi.rd_data[11:0];
                            2'd1: rght_ld   <= spi.rd_data[11:0];
                            2'd2: steer_pot <= spi.rd_data[11:0];
                            default: batt   <= spi.rd_data[11:0];
                        endcase
                        // Coincident with the rght_ld update.
                        if (rr == 2'd1) begin
                            ld_vld <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= IDLE;
                        a2d_err <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                CAPT: begin
                    rr    <= rr + 2'd1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
